dot_channel_seq: RTL



---
 rtl/dot_channel_seq_pkg.sv | 20 ++
 rtl/dot_channel_seq_watchdog.sv | 35 +++
 rtl/dot_channel_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dot_channel_seq_pkg.sv
// Shared definitions for the dot-channel sequencer: result width and FSM state encodings.
package dot_channel_seq_pkg;

  localparam int data_len = 16;

  localparam logic [2:0] SEQ_IDLE  = 3'd0;
  localparam logic [2:0] SEQ_LOAD  = 3'd1;
  localparam logic [2:0] SEQ_RUN   = 3'd2;
  localparam logic [2:0] SEQ_DRAIN = 3'd3;
  localparam logic [2:0] SEQ_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = SEQ_IDLE,
    ST_LOAD  = SEQ_LOAD,
    ST_RUN   = SEQ_RUN,
    ST_DRAIN = SEQ_DRAIN,
    ST_DONE  = SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/dot_channel_seq_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
module dot_channel_seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dot_channel_seq.sv
// Sequencer for one dot channel: sweeps (cs, phase), drives the load strobes,
// handshakes the feature source and forwards tagged results downstream.
module dot_channel_seq
  import dot_channel_seq_pkg::*;
#(
  parameter int NUM_CS    = 10,
  parameter int NUM_PHASE = 5,
  parameter int TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                src_valid,
  output logic                src_ack,
  output logic                ws_load,
  output logic                dc_load,
  output logic [3:0]          cs,
  output logic [2:0]          phase,
  input  logic                dc_valid,
  input  logic [data_len-1:0] dc_q,
  output logic                out_valid,
  output logic [data_len-1:0] out_data,
  output logic [3:0]          out_cs,
  output logic [2:0]          out_phase,
  output logic [2:0]          dbg_state
);

  // Handshake: upstream raises src_valid and holds d until the one-cycle
  // src_ack; downstream sees out_valid for exactly one cycle per result.

  localparam logic [3:0] CS_LAST = 4'(NUM_CS - 1);
  localparam logic [2:0] PH_LAST = 3'(NUM_PHASE - 1);

  seq_state_e          state_q, state_d;
  logic [3:0]          cs_q, cs_d;
  logic [2:0]          phase_q, phase_d;
  logic [data_len-1:0] out_data_q, out_data_d;
  logic [3:0]          out_cs_q, out_cs_d;
  logic [2:0]          out_phase_q, out_phase_d;
  logic                busy_q, busy_d;
  logic                ws_load_q, ws_load_d;
  logic                dc_load_q, dc_load_d;
  logic                result_q, result_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wd_clr, wd_en, wd_expire;

  assign wd_clr = (state_q != ST_RUN);
  assign wd_en  = (state_q == ST_RUN) && !dc_valid;

  dot_channel_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    phase_d     = phase_q;
    out_data_d  = out_data_q;
    out_cs_d    = out_cs_q;
    out_phase_d = out_phase_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (src_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dc_valid) begin
          out_data_d  = dc_q;
          out_cs_d    = cs_q;
          out_phase_d = phase_q;
          state_d     = ST_DRAIN;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          cs_d    = '0;
          phase_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Terminal compares come first so the indices never wrap.
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + 3'd1;
          state_d = ST_LOAD;
        end else if (cs_q != CS_LAST) begin
          phase_d = '0;
          cs_d    = cs_q + 4'd1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cs_d    = '0;
        phase_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cs_d    = '0;
        phase_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so every output leaves a flop.
    busy_d    = (state_d != ST_IDLE);
    ws_load_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    dc_load_d = (state_d == ST_RUN);
    result_d  = (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cs_q        <= '0;
      phase_q     <= '0;
      out_data_q  <= '0;
      out_cs_q    <= '0;
      out_phase_q <= '0;
      busy_q      <= 1'b0;
      ws_load_q   <= 1'b0;
      dc_load_q   <= 1'b0;
      result_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      phase_q     <= phase_d;
      out_data_q  <= out_data_d;
      out_cs_q    <= out_cs_d;
      out_phase_q <= out_phase_d;
      busy_q      <= busy_d;
      ws_load_q   <= ws_load_d;
      dc_load_q   <= dc_load_d;
      result_q    <= result_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign src_ack   = result_q;
  assign out_valid = result_q;
  assign ws_load   = ws_load_q;
  assign dc_load   = dc_load_q;
  assign cs        = cs_q;
  assign phase     = phase_q;
  assign out_data  = out_data_q;
  assign out_cs    = out_cs_q;
  assign out_phase = out_phase_q;
  assign dbg_state = state_q;

endmodule
